step_pulse_shaper: RTL and testbench

// Downstream stage of the acceleration profile generator. Consumes its single-cycle step/dir strobes and produces

---
 rtl/step_pulse_shaper.sv | 195 +++++++++++++++++++
 tb/tb_step_pulse_shaper.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_shaper.sv
// step_pulse_shaper
// Turns single-cycle step/dir strobes from the profile generator into STEP/DIR
// driver pins with programmable dir-setup, pulse-high and pulse-low timing.
// Strobes that arrive faster than the pin timing allows are held in a signed
// net-pending counter, so opposite steps cancel before they reach the pins.
// The absolute position of the pulses actually emitted is also tracked.
module step_pulse_shaper #(
  parameter int CNT_W  = 16,
  parameter int PEND_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     step_in,
  input  logic                     dir_in,
  input  logic [CNT_W-1:0]         dir_setup,
  input  logic [CNT_W-1:0]         pulse_width,
  input  logic [CNT_W-1:0]         pulse_gap,
  input  logic                     clear_overflow,
  output logic                     step_out,
  output logic                     dir_out,
  output logic                     busy,
  output logic signed [PEND_W-1:0] pending,
  output logic signed [31:0]       position,
  output logic                     overflow
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIR_SETUP  = 2'd1,
    PULSE_HIGH = 2'd2,
    PULSE_LOW  = 2'd3
  } state_t;

  // One guard bit above the pending width so a +/-1 strobe and a +/-1 issue
  // can be summed before the saturation decision.
  typedef logic signed [PEND_W:0] pext_t;

  localparam int    PEND_MAX = (2 ** (PEND_W - 1)) - 1;
  localparam pext_t P_MAX    = pext_t'(PEND_MAX);
  localparam pext_t P_ONE    = pext_t'(1);
  localparam pext_t P_NEG    = pext_t'(-1);
  localparam logic [CNT_W-1:0] T_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] timer;

  logic  want;
  logic  flip;
  logic  issue;
  logic  drop;
  pext_t pend_x;
  pext_t inc_x;
  pext_t iss_x;
  pext_t pend_next;

  // A programmed width or gap of zero still produces a one-cycle phase.
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? T_ONE : v;
  endfunction

  // Net pending update with saturation: the strobe is dropped if the combined
  // result leaves +/-PEND_MAX, but the issue decrement always applies. The
  // issue term moves toward zero, so the fallback is always in range.
  function automatic pext_t pend_update(input  pext_t cur,
                                        input  pext_t inc,
                                        input  pext_t iss,
                                        output logic  dropped);
    pext_t sum;
    sum = cur + inc - iss;
    if ((sum > P_MAX) || (sum < -P_MAX)) begin
      dropped = 1'b1;
      return cur - iss;
    end
    dropped = 1'b0;
    return sum;
  endfunction

  // Issue decision: a step leaves on this edge either straight from IDLE (no
  // reversal, or a reversal with zero setup) or at the end of the setup time.
  // If pending changed sign or emptied during setup, or the shaper was
  // disabled meanwhile, nothing is issued and IDLE re-evaluates.
  always_comb begin
    want  = (pending > 0);
    flip  = 1'b0;
    issue = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (pending != '0)) begin
          if (want != dir_out) begin
            flip  = 1'b1;
            issue = (dir_setup == '0);
          end else begin
            issue = 1'b1;
          end
        end
      end
      DIR_SETUP: begin
        issue = (timer == T_ONE) && enable && (pending != '0) && (want == dir_out);
      end
      default: begin
        issue = 1'b0;
      end
    endcase
  end

  // Net change to the pending count from this cycle's strobe and issue.
  always_comb begin
    pend_x    = pext_t'(pending);
    inc_x     = step_in ? (dir_in ? P_ONE : P_NEG) : '0;
    iss_x     = issue ? (want ? P_ONE : P_NEG) : '0;
    drop      = 1'b0;
    pend_next = pend_update(pend_x, inc_x, iss_x, drop);
  end

  // Pin timing FSM; timing inputs are captured only when a phase is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      step_out <= 1'b0;
      dir_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flip) begin
            dir_out <= want;
          end
          if (issue) begin
            step_out <= 1'b1;
            timer    <= at_least_one(pulse_width);
            state    <= PULSE_HIGH;
          end else if (flip) begin
            timer <= dir_setup;
            state <= DIR_SETUP;
          end
        end
        DIR_SETUP: begin
          if (issue) begin
            step_out <= 1'b1;
            timer    <= at_least_one(pulse_width);
            state    <= PULSE_HIGH;
          end else if (timer == T_ONE) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        PULSE_HIGH: begin
          if (timer == T_ONE) begin
            step_out <= 1'b0;
            timer    <= at_least_one(pulse_gap);
            state    <= PULSE_LOW;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        PULSE_LOW: begin
          if (timer == T_ONE) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pending count, emitted position and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      position <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pend_next[PEND_W-1:0];
      if (issue) begin
        position <= want ? (position + 32'sd1) : (position - 32'sd1);
      end
      if (clear_overflow) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Bench for step_pulse_shaper: a table of burst vectors plus hand-written
// sequences for cancellation, saturation, zero timing, reset and enable.
// Expected pulses are queued when stimulus is driven and popped when the DUT
// raises step_out.
module tb_step_pulse_shaper;
  localparam int CNT_W  = 16;
  localparam int PEND_W = 5;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     enable = 1'b1;
  logic                     step_in = 1'b0;
  logic                     dir_in = 1'b0;
  logic [CNT_W-1:0]         dir_setup = '0;
  logic [CNT_W-1:0]         pulse_width = '0;
  logic [CNT_W-1:0]         pulse_gap = '0;
  logic                     clear_overflow = 1'b0;
  logic                     step_out;
  logic                     dir_out;
  logic                     busy;
  logic signed [PEND_W-1:0] pending;
  logic signed [31:0]       position;
  logic                     overflow;

  step_pulse_shaper #(.CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .step_in(step_in), .dir_in(dir_in),
    .dir_setup(dir_setup), .pulse_width(pulse_width), .pulse_gap(pulse_gap),
    .clear_overflow(clear_overflow), .step_out(step_out), .dir_out(dir_out),
    .busy(busy), .pending(pending), .position(position), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dir;
    int   pos;
    int   width;
    int   rise;    // -1: not checked
    int   period;  // 0: not checked
  } pulse_t;

  typedef struct {
    int   ds;
    int   pw;
    int   pg;
    int   n;
    logic dir;
    int   peak;
  } vec_t;

  pulse_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  logic   prev_step = 1'b0;
  bit     in_pulse = 1'b0;
  int     rise_cyc = 0;
  int     last_rise = -1;
  int     cur_width = 0;
  int     peak = 0;
  logic   dir_hist [0:255];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input logic d, input int pos, input int w,
                              input int rise, input int per);
    pulse_t p;
    p.dir = d; p.pos = pos; p.width = w; p.rise = rise; p.period = per;
    exp_q.push_back(p);
  endtask

  task automatic monitor();
    int     ap;
    pulse_t e;
    ap = int'(pending);
    if (ap < 0) ap = -ap;
    if (ap > peak) peak = ap;
    if (cyc < 256) dir_hist[cyc] = dir_out;
    if (step_out && !prev_step) begin
      check("pulse_expected", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulse_dir", dir_out, e.dir);
        check("pulse_position", position, e.pos);
        if (e.rise >= 0) check("pulse_rise_cycle", cyc, e.rise);
        if (e.period > 0 && last_rise >= 0) check("pulse_period", cyc - last_rise, e.period);
        cur_width = e.width;
        in_pulse  = 1'b1;
      end
      rise_cyc  = cyc;
      last_rise = cyc;
    end
    if (!step_out && prev_step && in_pulse) begin
      check("pulse_width", cyc - rise_cyc, cur_width);
      in_pulse = 1'b0;
    end
    prev_step = step_out;
  endtask

  // Drives one cycle's strobe, then samples outputs at the following negedge.
  task automatic cycle(input logic s, input logic d);
    step_in = s;
    dir_in  = d;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    step_in        = 1'b0;
    clear_overflow = 1'b0;
    monitor();
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      cycle(1'b0, 1'b0);
      k++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    step_in = 1'b0;
    clear_overflow = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_step_out", step_out, 0);
    check("rst_dir_out", dir_out, 0);
    check("rst_pending", pending, 0);
    check("rst_position", position, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    reset     = 1'b0;
    cyc       = 0;
    prev_step = 1'b0;
    in_pulse  = 1'b0;
    last_rise = -1;
    peak      = 0;
    exp_q.delete();
  endtask

  task automatic set_timing(input int ds, input int pw, input int pg);
    dir_setup   = CNT_W'(ds);
    pulse_width = CNT_W'(pw);
    pulse_gap   = CNT_W'(pg);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vt [5];
    vec_t v;
    int   w;
    int   per;
    int   first;
    int   e_cyc;

    // {dir_setup, pulse_width, pulse_gap, strobes, dir, expected pending peak}
    vt[0] = '{3, 4, 2, 1, 1'b1, 1};
    vt[1] = '{3, 4, 2, 5, 1'b1, 4};
    vt[2] = '{0, 0, 0, 3, 1'b1, 2};
    vt[3] = '{2, 1, 3, 2, 1'b0, 1};
    vt[4] = '{5, 2, 1, 4, 1'b1, 4};

    // Burst vectors: strobes on consecutive cycles starting at cycle 10.
    for (int i = 0; i < 5; i++) begin
      v = vt[i];
      set_timing(v.ds, v.pw, v.pg);
      enable = 1'b1;
      do_reset();
      w     = (v.pw == 0) ? 1 : v.pw;
      per   = w + ((v.pg == 0) ? 1 : v.pg) + 1;
      first = 12 + ((v.dir && v.ds > 0) ? v.ds : 0);
      for (int k = 0; k < v.n; k++)
        expect_pulse(v.dir, v.dir ? (k + 1) : -(k + 1), w, (k == 0) ? first : -1, (k == 0) ? 0 : per);
      while (cyc < 10) cycle(1'b0, 1'b0);
      repeat (v.n) cycle(1'b1, v.dir);
      wait_idle(2000);
      check("vec_dir_c11", dir_hist[11], 0);
      check("vec_dir_c12", dir_hist[12], v.dir);
      check("vec_pending_end", pending, 0);
      check("vec_position_end", position, v.dir ? v.n : -v.n);
      check("vec_pending_peak", peak, v.peak);
      check("vec_overflow", overflow, 0);
      check("vec_missing_pulses", exp_q.size(), 0);
    end

    // Opposite strobes cancel while the first pulse is still pending setup.
    set_timing(3, 4, 2);
    do_reset();
    expect_pulse(1'b1, 1, 4, 15, 0);
    while (cyc < 10) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b1);
    repeat (2) cycle(1'b1, 1'b0);
    wait_idle(2000);
    check("cancel_pending", pending, 0);
    check("cancel_position", position, 1);
    check("cancel_dir_out", dir_out, 1);
    check("cancel_peak", peak, 3);
    check("cancel_missing_pulses", exp_q.size(), 0);

    // Saturation of pending and the sticky overflow flag.
    set_timing(3, 100, 2);
    do_reset();
    expect_pulse(1'b1, 1, 100, 15, 0);
    while (cyc < 10) cycle(1'b0, 1'b0);
    repeat (20) cycle(1'b1, 1'b1);
    check("sat_pending", pending, 15);
    check("sat_overflow", overflow, 1);
    check("sat_step_out", step_out, 1);
    clear_overflow = 1'b1;
    cycle(1'b1, 1'b1);
    check("sat_clear_wins", overflow, 0);
    check("sat_pending_hold", pending, 15);
    cycle(1'b1, 1'b1);
    check("sat_overflow_again", overflow, 1);
    clear_overflow = 1'b1;
    cycle(1'b0, 1'b0);
    check("sat_clear", overflow, 0);
    cycle(1'b1, 1'b0);
    check("sat_minus_accepted", pending, 14);
    check("sat_pulse_seen", exp_q.size(), 0);

    // Zero timing: one-cycle high/low, reversal emits with the dir flip.
    set_timing(0, 0, 0);
    do_reset();
    expect_pulse(1'b1, 1, 1, 12, 0);
    expect_pulse(1'b0, 0, 1, 22, 0);
    while (cyc < 10) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    while (cyc < 20) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    wait_idle(2000);
    check("zero_dir_c21", dir_hist[21], 1);
    check("zero_dir_c22", dir_hist[22], 0);
    check("zero_position", position, 0);
    check("zero_pending", pending, 0);
    check("zero_missing_pulses", exp_q.size(), 0);

    // Asynchronous reset in the middle of a pulse.
    set_timing(0, 10, 2);
    do_reset();
    expect_pulse(1'b1, 1, 10, 12, 0);
    while (cyc < 10) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    check("midrst_step_before", step_out, 1);
    check("midrst_pending_before", pending, 2);
    check("midrst_position_before", position, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_step_out", step_out, 0);
    check("midrst_pending", pending, 0);
    check("midrst_position", position, 0);

    // Disabled shaper holds pending, then drains it once enabled.
    set_timing(0, 2, 2);
    enable = 1'b0;
    do_reset();
    while (cyc < 10) cycle(1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);
    check("dis_pending", pending, 2);
    check("dis_busy", busy, 1);
    check("dis_position", position, 0);
    check("dis_step_out", step_out, 0);
    e_cyc = cyc;
    expect_pulse(1'b1, 1, 2, e_cyc + 1, 0);
    expect_pulse(1'b1, 2, 2, -1, 5);
    enable = 1'b1;
    wait_idle(2000);
    check("en_position", position, 2);
    check("en_pending", pending, 0);
    check("en_missing_pulses", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
